// File: rtl/decode_execute_pipe.sv
// F/D and D/E pipeline registers driven by hazard-unit stall/flush decisions,
// with E-stage operand forwarding and saturating stall/flush event counters.
module decode_execute_pipe #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iStallD,
  input  logic              iFlushD,
  input  logic              iFlushE,
  input  logic [31:0]       iInstrF,
  input  logic [ADDR_W-1:0] iPcF,
  input  logic [ADDR_W-1:0] iPcPlus4F,
  input  logic              iValidF,
  output logic [31:0]       oInstrD,
  output logic [ADDR_W-1:0] oPcD,
  output logic [ADDR_W-1:0] oPcPlus4D,
  output logic              oValidD,
  output logic [4:0]        oSrcReg1D,
  output logic [4:0]        oSrcReg2D,
  input  logic [DATA_W-1:0] iRegData1D,
  input  logic [DATA_W-1:0] iRegData2D,
  input  logic [DATA_W-1:0] iImmD,
  input  logic [CTRL_W-1:0] iCtrlD,
  input  logic              iRegWriteEnD,
  output logic [4:0]        oSrcReg1E,
  output logic [4:0]        oSrcReg2E,
  output logic [4:0]        oDestRegE,
  output logic              oRegWriteEnE,
  output logic              oValidE,
  output logic [CTRL_W-1:0] oCtrlE,
  output logic [DATA_W-1:0] oImmE,
  output logic [ADDR_W-1:0] oPcE,
  output logic [ADDR_W-1:0] oPcPlus4E,
  input  logic [2:0]        iForwardAluOp1,
  input  logic [2:0]        iForwardAluOp2,
  input  logic [DATA_W-1:0] iAluResultM,
  input  logic [DATA_W-1:0] iResultW,
  output logic [DATA_W-1:0] oAluOp1E,
  output logic [DATA_W-1:0] oAluOp2E,
  output logic [31:0]       oStallCycles,
  output logic [31:0]       oFlushCount
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [DATA_W-1:0] reg_data1_e;
  logic [DATA_W-1:0] reg_data2_e;
  logic [31:0]       stall_cycles_q;
  logic [31:0]       flush_count_q;
  logic              stall_inc;
  logic              flush_inc;

  // F/D register: flush beats stall, stall holds everything
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oInstrD   <= NOP;
      oPcD      <= '0;
      oPcPlus4D <= '0;
      oValidD   <= 1'b0;
    end else if (iFlushD) begin
      oInstrD   <= NOP;
      oPcD      <= '0;
      oPcPlus4D <= '0;
      oValidD   <= 1'b0;
    end else if (!iStallD) begin
      oInstrD   <= iInstrF;
      oPcD      <= iPcF;
      oPcPlus4D <= iPcPlus4F;
      oValidD   <= iValidF;
    end
  end

  assign oSrcReg1D = oInstrD[19:15];
  assign oSrcReg2D = oInstrD[24:20];

  // D/E register never holds; a stalled D must always be paired with a flushed E
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oSrcReg1E    <= '0;
      oSrcReg2E    <= '0;
      oDestRegE    <= '0;
      oRegWriteEnE <= 1'b0;
      oValidE      <= 1'b0;
      oCtrlE       <= '0;
      oImmE        <= '0;
      oPcE         <= '0;
      oPcPlus4E    <= '0;
      reg_data1_e  <= '0;
      reg_data2_e  <= '0;
    end else if (iFlushE) begin
      oSrcReg1E    <= '0;
      oSrcReg2E    <= '0;
      oDestRegE    <= '0;
      oRegWriteEnE <= 1'b0;
      oValidE      <= 1'b0;
      oCtrlE       <= '0;
      oImmE        <= '0;
      oPcE         <= '0;
      oPcPlus4E    <= '0;
      reg_data1_e  <= '0;
      reg_data2_e  <= '0;
    end else begin
      oSrcReg1E    <= oInstrD[19:15];
      oSrcReg2E    <= oInstrD[24:20];
      oDestRegE    <= oInstrD[11:7];
      oRegWriteEnE <= iRegWriteEnD & oValidD;
      oValidE      <= oValidD;
      oCtrlE       <= iCtrlD;
      oImmE        <= iImmD;
      oPcE         <= oPcD;
      oPcPlus4E    <= oPcPlus4D;
      reg_data1_e  <= iRegData1D;
      reg_data2_e  <= iRegData2D;
    end
  end

  // reserved select codes fall back to the registered regfile value
  always_comb begin
    oAluOp1E = reg_data1_e;
    case (iForwardAluOp1)
      3'b001:  oAluOp1E = iAluResultM;
      3'b010:  oAluOp1E = iResultW;
      default: oAluOp1E = reg_data1_e;
    endcase
  end

  always_comb begin
    oAluOp2E = reg_data2_e;
    case (iForwardAluOp2)
      3'b001:  oAluOp2E = iAluResultM;
      3'b010:  oAluOp2E = iResultW;
      default: oAluOp2E = reg_data2_e;
    endcase
  end

  // a flush overrides a stall in D, so that edge is not a stall cycle
  assign stall_inc = iStallD & ~iFlushD;
  assign flush_inc = iFlushD | iFlushE;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_inc && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_inc && (flush_count_q != 32'hFFFF_FFFF))
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign oStallCycles = stall_cycles_q;
  assign oFlushCount  = flush_count_q;

endmodule
